// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: dispatch admission controller and recovery sequencer.
// Each cycle it grants a thermometer of lanes sized by the scarcest
// resource. Dispatch is blocked for a fixed window after a branch
// hazard, and it stops for good once a halt instruction retires.
// Optional feature macro: DISPATCH_PERF_EN adds saturating counters
// that attribute stall and recovery cycles.
//
// The FSM state is visible through the recovering and halted outputs.
// The grant is purely combinational; only the FSM state and the
// recovery counter are registered.
module dispatch_ctrl #(
    parameter int N_WAY        = 2,
    parameter int N_ROB        = 32,
    parameter int N_PR         = 64,
    parameter int N_RS         = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [N_WAY-1:0]           inst_valid,
    input  logic [$clog2(N_ROB):0]     rob_free_cnt,
    input  logic [$clog2(N_PR):0]      fl_free_cnt,
    input  logic [$clog2(N_RS):0]      rs_free_cnt,
    input  logic                       branch_haz,
    input  logic [N_WAY-1:0]           retire_valid,
    input  logic [N_WAY-1:0]           retire_halt,
    output logic [N_WAY-1:0]           dispatch_en,
    output logic [$clog2(N_WAY):0]     dispatch_num,
    output logic                       dispatch_stall,
    output logic                       recovering,
    output logic                       halted
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]                perf_rob_stall,
    output logic [31:0]                perf_fl_stall,
    output logic [31:0]                perf_rs_stall,
    output logic [31:0]                perf_recover_cyc
`endif
);

    localparam int NUM_W = $clog2(N_WAY) + 1;
    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_HALTED  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic [31:0]      avail;
    logic             gap;
    logic [31:0]      rob_ext, fl_ext, rs_ext;
    logic [31:0]      min_w;
    logic [NUM_W-1:0] grant;
    logic             dispatch_ok;
    logic             halt_ret;

    assign halt_ret = |(retire_valid & retire_halt);
    assign rob_ext  = 32'(rob_free_cnt);
    assign fl_ext   = 32'(fl_free_cnt);
    assign rs_ext   = 32'(rs_free_cnt);

    // Count contiguous valid lanes from lane 0; anything after a gap waits.
    always_comb begin
        avail = 32'd0;
        gap   = 1'b0;
        for (int i = 0; i < N_WAY; i++) begin
            if (!inst_valid[i])
                gap = 1'b1;
            else if (!gap)
                avail = avail + 32'd1;
        end
    end

    // Grant is the minimum of demand, every resource count and the lane width.
    always_comb begin
        min_w = 32'(N_WAY);
        if (avail   < min_w) min_w = avail;
        if (rob_ext < min_w) min_w = rob_ext;
        if (fl_ext  < min_w) min_w = fl_ext;
        if (rs_ext  < min_w) min_w = rs_ext;
        grant = NUM_W'(min_w);
    end

    assign dispatch_ok = !reset && (state == ST_RUN) && !branch_haz;

    // Thermometer grant from lane 0, suppressed whenever dispatch is blocked.
    always_comb begin
        dispatch_en  = '0;
        dispatch_num = '0;
        if (dispatch_ok) begin
            dispatch_num = grant;
            for (int i = 0; i < N_WAY; i++)
                dispatch_en[i] = (32'(i) < 32'(grant));
        end
    end

    assign dispatch_stall = !reset && (state == ST_RUN) && (avail > 32'(dispatch_num));
    assign recovering     = !reset && (state == ST_RECOVER);
    assign halted         = !reset && (state == ST_HALTED);

    // Next-state logic: a retiring halt outranks a hazard in every state.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (halt_ret) begin
                    state_nxt = ST_HALTED;
                end else if (branch_haz) begin
                    state_nxt = ST_RECOVER;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            ST_RECOVER: begin
                if (halt_ret) begin
                    state_nxt = ST_HALTED;
                end else if (branch_haz) begin
                    cnt_nxt = CNT_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register with synchronous reset back to RUN.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

`ifdef DISPATCH_PERF_EN
    logic rob_lim, fl_lim, res_stall, blocked_haz;

    // The smallest resource sets the grant on a stall; ties favour ROB, then FL.
    assign rob_lim     = (rob_ext <= fl_ext) && (rob_ext <= rs_ext);
    assign fl_lim      = !rob_lim && (fl_ext <= rs_ext);
    assign res_stall   = dispatch_stall && !branch_haz;
    assign blocked_haz = (state == ST_RECOVER) || ((state == ST_RUN) && branch_haz);

    // Saturating event counters, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_rob_stall   <= '0;
            perf_fl_stall    <= '0;
            perf_rs_stall    <= '0;
            perf_recover_cyc <= '0;
        end else begin
            if (res_stall && rob_lim && (perf_rob_stall != 32'hFFFF_FFFF))
                perf_rob_stall <= perf_rob_stall + 32'd1;
            if (res_stall && fl_lim && (perf_fl_stall != 32'hFFFF_FFFF))
                perf_fl_stall <= perf_fl_stall + 32'd1;
            if (res_stall && !rob_lim && !fl_lim && (perf_rs_stall != 32'hFFFF_FFFF))
                perf_rs_stall <= perf_rs_stall + 32'd1;
            if (blocked_haz && (perf_recover_cyc != 32'hFFFF_FFFF))
                perf_recover_cyc <= perf_recover_cyc + 32'd1;
        end
    end
`endif

endmodule
